// File: rtl/axi_slave_mem.sv
// axi_slave_mem
//   AXI4 responder that terminates write and read bursts into an internal
//   dual-port word memory. Write and read channels are independent, with
//   one outstanding burst per direction and one beat per cycle.
//
// Ports
//   s_axi_aclk, s_axi_areset     clock, synchronous active-high reset
//   s_axi_aw*                    write address channel (in, awready out)
//   s_axi_w*                     write data channel (in, wready out)
//   s_axi_b*                     write response channel (out, bready in)
//   s_axi_ar*                    read address channel (in, arready out)
//   s_axi_r*                     read data channel (out, rready in)
//
// Every output comes straight from a register.
module axi_slave_mem #(
    parameter int S_AXI_ADDR     = 40,
    parameter int S_AXI_ID       = 16,
    parameter int S_AXI_DATA     = 128,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic [S_AXI_ADDR-1:0]   s_axi_awaddr,
    input  logic [S_AXI_ID-1:0]     s_axi_awid,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [S_AXI_DATA-1:0]   s_axi_wdata,
    input  logic [S_AXI_DATA/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic [S_AXI_ID-1:0]     s_axi_bid,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [S_AXI_ADDR-1:0]   s_axi_araddr,
    input  logic [S_AXI_ID-1:0]     s_axi_arid,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [S_AXI_DATA-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic [S_AXI_ID-1:0]     s_axi_rid,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB  = S_AXI_DATA / 8;
    localparam int LSB   = $clog2(STRB);
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

    localparam logic [2:0] FULL_SIZE   = 3'(LSB);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [MEM_DEPTH_LOG2-1:0] IDX_ONE = MEM_DEPTH_LOG2'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [S_AXI_DATA-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wstate_t                   r_wstate, w_wstate_nxt;
    logic [MEM_DEPTH_LOG2-1:0] r_widx;
    logic [S_AXI_ID-1:0]       r_wid;
    logic [7:0]                r_wlen, r_wcnt;
    logic                      r_wfixed, r_wsupp, r_werr;
    logic                      r_awready, r_wready, r_bvalid;
    logic [1:0]                r_bresp;
    logic [S_AXI_ID-1:0]       r_bid;

    logic w_aw_hs, w_w_hs, w_b_hs, w_w_last, w_wlast_bad, w_aw_bad, w_mem_we;

    assign w_aw_hs     = s_axi_awvalid & r_awready;
    assign w_w_hs      = s_axi_wvalid & r_wready;
    assign w_b_hs      = s_axi_bready & r_bvalid;
    assign w_w_last    = (r_wcnt == r_wlen);
    // Burst length is governed by awlen; wlast only contributes to the response.
    assign w_wlast_bad = w_w_hs & (s_axi_wlast != w_w_last);
    assign w_aw_bad    = (s_axi_awburst == BURST_RSVD) | (s_axi_awsize != FULL_SIZE);
    // A beat landing on the reset edge belongs to a dropped burst.
    assign w_mem_we    = w_w_hs & ~r_wsupp & ~s_axi_areset;

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs)             w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_w_last)  w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs)              w_wstate_nxt = W_IDLE;
            default:                          w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) r_wstate <= W_IDLE;
        else              r_wstate <= w_wstate_nxt;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_bid     <= '0;
            r_widx    <= '0;
            r_wid     <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_wfixed  <= 1'b0;
            r_wsupp   <= 1'b0;
            r_werr    <= 1'b0;
        end else begin
            // Ready/valid registers track the state being entered.
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_widx   <= s_axi_awaddr[LSB +: MEM_DEPTH_LOG2];
                r_wid    <= s_axi_awid;
                r_wlen   <= s_axi_awlen;
                r_wcnt   <= '0;
                r_wfixed <= (s_axi_awburst == BURST_FIXED);
                r_wsupp  <= w_aw_bad;
                r_werr   <= w_aw_bad;
            end
            if (w_w_hs) begin
                r_wcnt <= r_wcnt + 8'd1;
                if (!r_wfixed)   r_widx <= r_widx + IDX_ONE;
                if (w_wlast_bad) r_werr <= 1'b1;
                if (w_w_last) begin
                    r_bresp <= (r_werr | w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                    r_bid   <= r_wid;
                end
            end
        end
    end

    // Memory is never cleared by reset.
    always_ff @(posedge s_axi_aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB; b++) begin
                if (s_axi_wstrb[b]) r_mem[r_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bid     = r_bid;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rstate_t                   r_rstate, w_rstate_nxt;
    logic [MEM_DEPTH_LOG2-1:0] r_ridx;
    logic [7:0]                r_rlen, r_rcnt;
    logic                      r_rfixed, r_rerr;
    logic                      r_arready, r_rvalid, r_rlast;
    logic [S_AXI_DATA-1:0]     r_rdata;
    logic [1:0]                r_rresp;
    logic [S_AXI_ID-1:0]       r_rid;

    logic                      w_ar_hs, w_r_hs, w_ar_bad;
    logic [MEM_DEPTH_LOG2-1:0] w_ar_idx, w_ridx_nxt;

    assign w_ar_hs    = s_axi_arvalid & r_arready;
    assign w_r_hs     = r_rvalid & s_axi_rready;
    assign w_ar_bad   = (s_axi_arburst == BURST_RSVD) | (s_axi_arsize != FULL_SIZE);
    assign w_ar_idx   = s_axi_araddr[LSB +: MEM_DEPTH_LOG2];
    assign w_ridx_nxt = r_rfixed ? r_ridx : r_ridx + IDX_ONE;

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)            w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast)  w_rstate_nxt = R_IDLE;
            default:                         w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) r_rstate <= R_IDLE;
        else              r_rstate <= w_rstate_nxt;
    end

    // Reads sample the memory before any same-edge write lands (read-first).
    // rdata only moves on an AR or R handshake, so it holds during stalls.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rid     <= '0;
            r_ridx    <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rfixed  <= 1'b0;
            r_rerr    <= 1'b0;
        end else begin
            r_arready <= (w_rstate_nxt == R_IDLE);
            if (w_ar_hs) begin
                r_ridx   <= w_ar_idx;
                r_rlen   <= s_axi_arlen;
                r_rcnt   <= '0;
                r_rfixed <= (s_axi_arburst == BURST_FIXED);
                r_rerr   <= w_ar_bad;
                r_rvalid <= 1'b1;
                r_rid    <= s_axi_arid;
                r_rresp  <= w_ar_bad ? RESP_SLVERR : RESP_OKAY;
                r_rlast  <= (s_axi_arlen == 8'd0);
                r_rdata  <= w_ar_bad ? '0 : r_mem[w_ar_idx];
            end else if (w_r_hs) begin
                if (r_rlast) begin
                    r_rvalid <= 1'b0;
                    r_rlast  <= 1'b0;
                end else begin
                    r_ridx  <= w_ridx_nxt;
                    r_rcnt  <= r_rcnt + 8'd1;
                    r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                    r_rdata <= r_rerr ? '0 : r_mem[w_ridx_nxt];
                end
            end
        end
    end

    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rid     = r_rid;

    // Byte-offset and upper address bits carry no meaning here.
    logic w_unused_addr;
    assign w_unused_addr = ^{s_axi_awaddr, s_axi_araddr};

endmodule
